// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_DATA_W = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0]   operand_i,
  input  logic                bit_i,
  input  logic                is_div_i,
  output logic [2*DATA_W-1:0] acc_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;

  // Multiply: upper half accumulates, product bits shift down into the lower half.
  // Divide: upper half is the partial remainder, lower half collects quotient bits.
  always_comb begin
    sum     = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + (bit_i ? {1'b0, operand_i} : '0);
    partial = {acc_i[2*DATA_W-1:DATA_W], bit_i};
    diff    = partial - {1'b0, operand_i};
    if (is_div_i) begin
      if (!diff[DATA_W]) begin
        acc_o = {diff[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_o = {partial[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: FSM, operand/sign tracking and architectural HI/LO.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned   CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  mdu_state_e          state_q, state_d;
  mdu_op_e             op_q, op_d;
  logic [DATA_W-1:0]   rs_q, rs_d, rt_q, rt_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, acc_step;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d, rem_neg_q, rem_neg_d, div_zero_q, div_zero_d;
  logic                is_div, is_signed, sa, sb;

  assign is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign sa        = is_signed & rs_q[DATA_W-1];
  assign sb        = is_signed & rt_q[DATA_W-1];

  // opa holds multiplicand/dividend, opb holds multiplier/divisor (both magnitudes).
  mdu_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .acc_i    (acc_q),
    .operand_i(is_div ? opb_q : opa_q),
    .bit_i    (is_div ? opa_q[DATA_W-1] : opb_q[0]),
    .is_div_i (is_div),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = mdu_op_e'(op_i);
          rs_d    = rs_data_i;
          rt_d    = rt_data_i;
          state_d = StPrep;
        end
      end
      StPrep: begin
        opa_d      = sa ? -rs_q : rs_q;
        opb_d      = sb ? -rt_q : rt_q;
        neg_d      = sa ^ sb;
        rem_neg_d  = sa;
        acc_d      = '0;
        cnt_d      = '0;
        div_zero_d = is_div && (rt_q == '0);
        state_d    = (is_div && (rt_q == '0)) ? StFix : StCalc;
      end
      StCalc: begin
        acc_d = acc_step;
        if (is_div) begin
          opa_d = opa_q << 1;
        end else begin
          opb_d = opb_q >> 1;
        end
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        if (div_zero_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else if (is_div) begin
          lo_d = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_d = rem_neg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      op_q       <= MDU_MULT;
      rs_q       <= '0;
      rt_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, scoreboard and reset/ignore sequences.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int unsigned W       = 32;
  localparam int          CalcLat = W + 2;
  localparam int          ZeroLat = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs, rt;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[14];

  always #5 clk = ~clk;

  mdu_ctrl #(
    .DATA_W(W)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .rs_data_i(rs),
    .rt_data_i(rt),
    .busy_o   (busy),
    .done_o   (done),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse retires the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_o=1, expected no outstanding request");
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_hi"}, hi, mon_e.hi);
        check({mon_e.name, "_lo"}, lo, mon_e.lo);
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input int poke_at);
    int   lat;
    int   busy_cnt;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    e.hi   = ehi;
    e.lo   = elo;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    // Scramble inputs after the accepting edge; the DUT must use its latched copies.
    start    = 1'b0;
    op       = ~o;
    rs       = ~a;
    rt       = ~b;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      start = (lat == poke_at);
      if (lat == poke_at) begin
        op = MDU_MULTU;
        rs = 32'hdead_beef;
        rt = 32'h1234_5678;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy) busy_cnt++;
    check({name, "_latency"}, lat, elat);
    check({name, "_busy_cycles"}, busy_cnt, elat + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_done;
    vecs = '{
      '{MDU_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, CalcLat, "mult_7_m3"},
      '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, CalcLat, "multu_max"},
      '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, CalcLat, "div_m7_2"},
      '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'hE,         CalcLat, "divu_100_7"},
      '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, CalcLat, "div_min_m1"},
      '{MDU_DIV,   32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, ZeroLat, "div_by_zero"},
      '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, CalcLat, "div_7_m2"},
      '{MDU_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         CalcLat, "div_m8_m3"},
      '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         CalcLat, "mult_min_min"},
      '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, CalcLat, "multu_max_2"},
      '{MDU_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, CalcLat, "divu_max_16"},
      '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, ZeroLat, "divu_by_zero"},
      '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         CalcLat, "mult_m1_m1"},
      '{MDU_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, ZeroLat, "div_neg_zero"}
    };

    // Reset held with start asserted: reset must win.
    rst   = 1'b0;
    start = 1'b1;
    op    = MDU_MULT;
    rs    = 32'd9;
    rt    = 32'd9;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    start = 1'b0;
    rst   = 1'b1;

    // Table vectors, issued back-to-back in the first IDLE cycle after each DONE.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].lat, -1);
    end

    // Start pulsed mid-CALC must be ignored; the next request follows in the first IDLE cycle.
    run_op("multu_poked", MDU_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, CalcLat, 10);
    run_op("divu_after_done", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'hE, CalcLat, -1);

    // Abort a DIV at iteration 10 with reset (start also high to exercise priority).
    @(negedge clk);
    start = 1'b1;
    op    = MDU_DIV;
    rs    = 32'h7FFF_0000;
    rt    = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    rst       = 1'b1;
    start     = 1'b0;
    seen_done = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);

    run_op("mult_3_5", MDU_MULT, 32'd3, 32'd5, 32'd0, 32'd15, CalcLat, -1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
